// File: rtl/compression_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : compression_engine
// Function : dictionary compressor that maps 80-bit words to 8-bit indices
//            and expands indices back into words.
// Revision : 1.0
// ============================================================================
module compression_engine #(
  parameter int DICT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] data_in,
  input  logic [7:0]  compressed_in,
  input  logic [1:0]  command,
  output logic [7:0]  compressed_out,
  output logic [79:0] decompressed_out,
  output logic [1:0]  response
);

  localparam int         c_ADDR_W = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
  localparam logic [8:0] c_DEPTH  = 9'(DICT_DEPTH);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_SEARCH = 1'b1;

  localparam logic [1:0] c_CMD_COMPRESS   = 2'b01;
  localparam logic [1:0] c_CMD_DECOMPRESS = 2'b10;
  localparam logic [1:0] c_CMD_ILLEGAL    = 2'b11;

  localparam logic [1:0] c_RSP_NONE  = 2'b00;
  localparam logic [1:0] c_RSP_COMP  = 2'b01;
  localparam logic [1:0] c_RSP_DECOMP = 2'b10;
  localparam logic [1:0] c_RSP_ERROR = 2'b11;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;

  logic [79:0] r_dict [DICT_DEPTH];
  logic [8:0]  r_cnt;
  logic [7:0]  r_idx;
  logic [79:0] r_word;
  logic        r_dec_pend;
  logic [7:0]  r_dec_idx;
  logic        r_ill_pend;
  logic [7:0]  r_comp_out;
  logic [79:0] r_decomp_out;
  logic [1:0]  r_response;

  logic [8:0]  w_cnt_m1;
  logic [79:0] w_entry;
  logic        w_start;
  logic        w_hit;
  logic        w_last;
  logic        w_insert;
  logic        w_full;
  logic        w_done;
  logic        w_dec_req;
  logic        w_ill_req;
  logic        w_dec_ok;

  assign w_cnt_m1 = r_cnt - 9'd1;
  assign w_entry  = r_dict[r_idx[c_ADDR_W-1:0]];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (command == c_CMD_COMPRESS) begin
          w_state_nxt = c_SEARCH;
        end
      end
      c_SEARCH: begin
        if (w_done) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Decode of the current cycle's actions; an empty dictionary never hits
  always_comb begin
    w_start   = 1'b0;
    w_dec_req = 1'b0;
    w_ill_req = 1'b0;
    w_hit     = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_start   = (command == c_CMD_COMPRESS);
        w_dec_req = (command == c_CMD_DECOMPRESS);
        w_ill_req = (command == c_CMD_ILLEGAL);
      end
      c_SEARCH: begin
        w_hit  = (r_cnt != 9'd0) && (w_entry == r_word);
        w_last = (r_cnt == 9'd0) || ({1'b0, r_idx} == w_cnt_m1);
      end
      default: ;
    endcase
    w_insert = w_last && !w_hit && (r_cnt < c_DEPTH);
    w_full   = w_last && !w_hit && (r_cnt >= c_DEPTH);
    w_done   = w_hit || w_last;
    w_dec_ok = ({1'b0, r_dec_idx} < r_cnt);
  end

  // Dictionary storage is not reset; r_cnt alone defines validity
  always_ff @(posedge clk) begin
    if (w_insert) begin
      r_dict[r_cnt[c_ADDR_W-1:0]] <= r_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 9'd0;
      r_idx        <= 8'd0;
      r_word       <= 80'd0;
      r_dec_pend   <= 1'b0;
      r_dec_idx    <= 8'd0;
      r_ill_pend   <= 1'b0;
      r_comp_out   <= 8'd0;
      r_decomp_out <= 80'd0;
      r_response   <= c_RSP_NONE;
    end else begin
      r_response <= c_RSP_NONE;
      r_dec_pend <= w_dec_req;
      r_ill_pend <= w_ill_req;

      if (w_start) begin
        r_word <= data_in;
        r_idx  <= 8'd0;
      end else if ((r_state == c_SEARCH) && !w_done) begin
        r_idx <= r_idx + 8'd1;
      end

      if (w_dec_req) begin
        r_dec_idx <= compressed_in;
      end

      if (w_hit) begin
        r_comp_out <= r_idx;
        r_response <= c_RSP_COMP;
      end else if (w_insert) begin
        r_comp_out <= r_cnt[7:0];
        r_cnt      <= r_cnt + 9'd1;
        r_response <= c_RSP_COMP;
      end else if (w_full) begin
        r_comp_out <= 8'd0;
        r_response <= c_RSP_ERROR;
      end

      // Deferred results of commands accepted on the previous edge in IDLE
      if (r_dec_pend) begin
        if (w_dec_ok) begin
          r_decomp_out <= r_dict[r_dec_idx[c_ADDR_W-1:0]];
          r_response   <= c_RSP_DECOMP;
        end else begin
          r_decomp_out <= 80'd0;
          r_response   <= c_RSP_ERROR;
        end
      end else if (r_ill_pend) begin
        r_response <= c_RSP_ERROR;
      end
    end
  end

  assign compressed_out   = r_comp_out;
  assign decompressed_out = r_decomp_out;
  assign response         = r_response;

endmodule
`default_nettype wire

// File: tb/tb_compression_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_compression_engine
// Function : scoreboard bench for compression_engine with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_compression_engine;

  logic        clk;
  logic        reset;
  logic [79:0] data_in;
  logic [7:0]  compressed_in;
  logic [1:0]  command;
  logic [7:0]  compressed_out;
  logic [79:0] decompressed_out;
  logic [1:0]  response;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [7:0]  comp;
    logic [79:0] dec;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  compression_engine #(.DICT_DEPTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .command          (command),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every non-idle response must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (response != 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_response: got resp=%b comp=%0d at cyc %0d, required no response",
                 response, compressed_out, cyc);
      end else begin
        e = sb.pop_front();
        if (response !== e.resp || compressed_out !== e.comp ||
            decompressed_out !== e.dec || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL result: got resp=%b comp=%0d dec=%h cyc=%0d, required resp=%b comp=%0d dec=%h cyc=%0d",
                   response, compressed_out, decompressed_out, cyc,
                   e.resp, e.comp, e.dec, e.cyc);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL timeout: got %0d pending results, required 0", sb.size());
    sb.delete();
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [79:0] data,
                       input logic [7:0] cin, input int lat,
                       input logic [1:0] resp, input logic [7:0] comp,
                       input logic [79:0] dec);
    @(posedge clk);
    #2;
    command       = cmd;
    data_in       = data;
    compressed_in = cin;
    sb.push_back('{cyc + 1 + lat, resp, comp, dec});
    @(posedge clk);
    #2;
    command = 2'b00;
    wait_drain();
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (response !== 2'b00 || compressed_out !== 8'd0 || decompressed_out !== 80'd0) begin
      miscompares++;
      $display("FAIL %s: got resp=%b comp=%0d dec=%h, required all zero",
               name, response, compressed_out, decompressed_out);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_outputs");
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  localparam logic [79:0] W_A = 80'hA;
  localparam logic [79:0] W_B = 80'hB;
  localparam logic [79:0] W_C = 80'hC0FFEE;
  localparam logic [79:0] W_D = 80'hDEAD_BEEF_0000_1234_5678;
  localparam logic [79:0] W_X = 80'hFFFF_0000_FFFF_0000_FFFF;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    command       = 2'b00;
    data_in       = 80'd0;
    compressed_in = 8'd0;
    #12;
    check_zero("initial_reset");
    reset = 1'b0;

    // First insert into an empty dictionary
    issue(2'b01, 80'h1, 8'd0, 1, 2'b01, 8'd0, 80'd0);

    // A, B, A on a fresh dictionary; the repeat hits index 0 after one edge
    do_reset();
    issue(2'b01, W_A, 8'd0, 1, 2'b01, 8'd0, 80'd0);
    issue(2'b01, W_B, 8'd0, 1, 2'b01, 8'd1, 80'd0);
    issue(2'b01, W_A, 8'd0, 1, 2'b01, 8'd0, 80'd0);

    // Decompress valid and out-of-range indices
    issue(2'b10, 80'd0, 8'd1, 1, 2'b10, 8'd0, W_B);
    issue(2'b10, 80'd0, 8'd2, 1, 2'b11, 8'd0, 80'd0);
    issue(2'b01, W_C, 8'd0, 2, 2'b01, 8'd2, 80'd0);
    issue(2'b10, 80'd0, 8'd2, 1, 2'b10, 8'd2, W_C);
    issue(2'b10, 80'd0, 8'd3, 1, 2'b11, 8'd2, 80'd0);

    // Illegal command: single error pulse, outputs held
    issue(2'b11, 80'd0, 8'd0, 1, 2'b11, 8'd2, 80'd0);

    // DECOMPRESS driven during SEARCH must be ignored
    @(posedge clk);
    #2;
    command = 2'b01;
    data_in = W_D;
    sb.push_back('{cyc + 1 + 3, 2'b01, 8'd3, 80'd0});
    @(posedge clk);
    #2;
    command       = 2'b10;
    compressed_in = 8'd0;
    @(posedge clk);
    #2;
    command = 2'b00;
    wait_drain();

    // Hit deeper in the dictionary
    issue(2'b01, W_C, 8'd0, 3, 2'b01, 8'd2, 80'd0);

    // Fill all 16 entries, then overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(2'b01, 80'h1000 + 80'(i), 8'd0, (i < 1) ? 1 : i, 2'b01, 8'(i), 80'd0);
    end
    issue(2'b01, W_X, 8'd0, 16, 2'b11, 8'd0, 80'd0);
    issue(2'b10, 80'd0, 8'd15, 1, 2'b10, 8'd0, 80'h100F);
    issue(2'b10, 80'd0, 8'd16, 1, 2'b11, 8'd0, 80'd0);
    issue(2'b10, 80'd0, 8'd15, 1, 2'b10, 8'd0, 80'h100F);

    // Reset mid-SEARCH aborts with no response and no insertion
    @(posedge clk);
    #2;
    command = 2'b01;
    data_in = W_X;
    @(posedge clk);
    #2;
    command = 2'b00;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_mid_search");
    #10;
    reset = 1'b0;
    issue(2'b10, 80'd0, 8'd0, 1, 2'b11, 8'd0, 80'd0);
    issue(2'b01, W_X, 8'd0, 1, 2'b01, 8'd0, 80'd0);
    issue(2'b10, 80'd0, 8'd0, 1, 2'b10, 8'd0, W_X);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compression_engine.md
COMPRESSION_ENGINE -- requirements
Module: compression_engine

Interface
REQ-001 The block SHALL have parameter DICT_DEPTH, default 16, legal range 1..256: number of dictionary entries.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port data_in, input, 80 bits: word to compress.
REQ-005 The block SHALL have port compressed_in, input, 8 bits: dictionary index to decompress.
REQ-006 The block SHALL have port command, input, 2 bits: 00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 illegal.
REQ-007 The block SHALL have port compressed_out, output, 8 bits: registered index result of a COMPRESS.
REQ-008 The block SHALL have port decompressed_out, output, 80 bits: registered word result of a DECOMPRESS.
REQ-009 The block SHALL have port response, output, 2 bits: 00 none, 01 compress done, 10 decompress done, 11 error.

Function
REQ-010 The block SHALL hold a dictionary of DICT_DEPTH 80-bit entries plus a fill count cnt (0..DICT_DEPTH); valid entries are indices 0..cnt-1.
REQ-011 The FSM SHALL have states IDLE and SEARCH; command is sampled only on edges where the state is IDLE and is ignored in SEARCH.
REQ-012 Edge T0, IDLE, command 00 SHALL leave the block in IDLE with no state change.
REQ-013 Edge T0, IDLE, command 01 SHALL latch data_in, set search index idx=0, and enter SEARCH; with cnt=0 the block SHALL go directly to the miss handling of REQ-015 at T0+1.
REQ-014 In SEARCH, each edge SHALL compare the latched word with entry idx; on a match it SHALL load compressed_out=idx and response=01, then return to IDLE; otherwise idx increments.
REQ-015 On a miss, when idx=cnt-1 compares unequal (or cnt=0): if cnt<DICT_DEPTH, entry cnt SHALL be written, compressed_out=cnt, cnt increments, and response=01; if cnt=DICT_DEPTH, compressed_out=0, response=11, and the dictionary is unchanged; both cases return to IDLE.
REQ-016 Latency SHALL be: hit at index k -> result on edge T0+k+1; miss with cnt=n -> result on edge T0+max(n,1).
REQ-017 Edge T0, IDLE, command 10 SHALL, on edge T0+1: if compressed_in<cnt, load decompressed_out=entry[compressed_in] and response=10; else load decompressed_out=0 and response=11; the state stays IDLE.
REQ-018 Edge T0, IDLE, command 11 SHALL load response=11 on edge T0+1 and change no other state.
REQ-019 response SHALL be a one-cycle pulse and return to 00 on the next edge unless a new result is produced on that edge.
REQ-020 compressed_out SHALL change only on COMPRESS results and decompressed_out only on DECOMPRESS results; each holds its value otherwise.
REQ-021 A DECOMPRESS accepted on the edge after a COMPRESS result SHALL see the entry inserted by that COMPRESS.
REQ-022 Index widths SHALL be 8 bits; unused upper bits of compressed_out SHALL be 0 when DICT_DEPTH<256.

Reset
REQ-023 reset high SHALL immediately, independent of clk, force state IDLE, cnt=0, idx=0, compressed_out=0, decompressed_out=0, and response=00.
REQ-024 Dictionary entry contents need not be cleared by reset; because cnt=0, no entry is valid after reset.
REQ-025 Reset asserted during SEARCH SHALL abort the operation with no insertion and no response.
REQ-026 The first command SHALL be sampled on the first rising edge after reset deasserts.

Verification
REQ-027 Scenario: reset, COMPRESS 80'h1 -> one edge later response=01, compressed_out=0, cnt=1.
REQ-028 Scenario: COMPRESS 80'hA, 80'hB, 80'hA (each after the previous response) -> compressed_out 0, 1, then 0; the third result arrives 1 edge after its command.
REQ-029 Scenario: fill 16 distinct words, then COMPRESS a 17th new word -> response=11 after 16 edges, compressed_out=0; a following DECOMPRESS 15 returns word 16.
REQ-030 Scenario: after 3 inserts, DECOMPRESS 2 -> response=10 with entry 2; DECOMPRESS 3 -> response=11, decompressed_out=0.
REQ-031 Scenario: command 10 driven while in SEARCH -> ignored; exactly one response (the compress result); command 11 from IDLE -> response=11 pulse of one cycle.
REQ-032 Scenario: reset pulsed mid-SEARCH -> outputs 0 immediately; a subsequent COMPRESS of the same word inserts at index 0.
